gen_scan_ctrl: RTL and testbench
================================

GEN_SCAN_CTRL -- requirements
Module: gen_scan_ctrl

Interface
REQ-001 Parameter FIELD_W, 32, field width in cells (>=2).
REQ-002 Parameter FIELD_H, 15, field height in cells (>=2).
REQ-003 Derived widths: X_ADR_SIZE = $clog2(FIELD_W), Y_ADR_SIZE = $clog2(FIELD_H).
REQ-004 i_clk  input  1  single clock; all state on rising edge.
REQ-005 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 i_start  input  1  request one full-field scan (one generation).
REQ-007 i_ready  input  1  downstream accepts current coordinate.
REQ-008 o_x  output  X_ADR_SIZE  current cell column.
REQ-009 o_y  output  Y_ADR_SIZE  current cell row.
REQ-010 o_valid  output  1  o_x/o_y valid for handshake.
REQ-011 o_last  output  1  current coordinate is final cell (FIELD_W-1, FIELD_H-1).
REQ-012 o_busy  output  1  scan in progress (state SCAN or DONE).
REQ-013 o_done  output  1  one-cycle pulse after final cell accepted.
REQ-014 o_gen_cnt  output  16  completed-generation count (present only with GEN_CNT_EN).

Function
REQ-015 Coordinate advance SHALL use an instance of get_next_coords (same FIELD_W/FIELD_H): raster order, x increments first, x wraps FIELD_W-1 -> 0 with y+1, y wraps FIELD_H-1 -> 0.
REQ-016 FSM states IDLE, SCAN, DONE; encoding free.
REQ-017 IDLE: o_valid=0, o_busy=0, o_x=o_y=0; i_start=1 -> SCAN next cycle.
REQ-018 SCAN: o_valid=1, o_busy=1; first cycle presents (0,0).
REQ-019 Handshake = o_valid & i_ready at clock edge; on handshake non-last coordinate advances to get_next_coords output.
REQ-020 Without handshake, o_x/o_y/o_valid SHALL hold stable (no drop of valid, no coordinate change).
REQ-021 o_last = o_valid & (o_x==FIELD_W-1) & (o_y==FIELD_H-1), combinational from state/registers.
REQ-022 Handshake while o_last=1 -> DONE next cycle; o_x/o_y reset to 0; o_valid=0.
REQ-023 DONE: o_done=1 for exactly one cycle, o_busy=1, then IDLE unconditionally.
REQ-024 i_start ignored in SCAN and DONE; no queuing; start needs i_start=1 sampled in IDLE.
REQ-025 i_start held high continuously -> back-to-back scans with one IDLE cycle between DONE and next SCAN.
REQ-026 Latency with i_ready=1 always: i_start at edge N -> (0,0) valid cycle N+1, last cell cycle N+FIELD_W*FIELD_H, o_done cycle N+FIELD_W*FIELD_H+1.
REQ-027 Exactly FIELD_W*FIELD_H handshakes per scan, each coordinate exactly once.
REQ-028 i_ready while o_valid=0 has no effect.

Reset
REQ-029 i_rst_n=0 SHALL asynchronously force IDLE, o_x=0, o_y=0, o_valid=0, o_last=0, o_busy=0, o_done=0, o_gen_cnt=0.
REQ-030 Reset mid-SCAN or in DONE aborts scan; no o_done, no count increment; first start after release scans from (0,0).
REQ-031 Reset release synchronous-safe: no state change on first edge after release unless i_start=1 in IDLE.

Configuration
REQ-032 Macro GEN_SCAN_GEN_CNT_EN defined: o_gen_cnt port present, increments by 1 on each DONE cycle (registered, visible cycle after o_done), wraps 16'hFFFF -> 0.
REQ-033 Macro undefined: o_gen_cnt port and counter absent; all other behaviour identical.

Verification (FIELD_W=32, FIELD_H=15, 480 cells)
REQ-034 Reset, i_start=0 for 10 cycles -> o_valid=0, o_busy=0, o_x=o_y=0 throughout.
REQ-035 i_start pulse, i_ready=1 -> 480 valid cycles in raster order (0,0),(1,0)..(31,0),(0,1)..(31,14); o_last only on (31,14); o_done one cycle after; o_gen_cnt=1.
REQ-036 i_ready random ~50% -> sequence identical to REQ-035; coords stable across every non-ready cycle; still 480 handshakes.
REQ-037 i_start held high for 3 scans -> 3 o_done pulses, one IDLE cycle each gap, o_gen_cnt=3.
REQ-038 Assert i_rst_n=0 asynchronously at coordinate (5,7) -> outputs zero immediately, no o_done, o_gen_cnt unchanged at 0; next scan starts at (0,0).
REQ-039 i_start pulsed during SCAN at (10,2) -> ignored; scan completes normally, single o_done.

Source files
------------

// File: rtl/gen_scan_ctrl.sv
// rtl/gen_scan_ctrl.sv - raster-order field scan controller with valid/ready coordinate handshake
// Optional completed-generation counter port o_gen_cnt enabled by GEN_SCAN_GEN_CNT_EN.

module get_next_coords #(
    parameter  int FIELD_W    = 32,
    parameter  int FIELD_H    = 15,
    localparam int X_ADR_SIZE = $clog2(FIELD_W),
    localparam int Y_ADR_SIZE = $clog2(FIELD_H)
) (
    input  logic [X_ADR_SIZE-1:0] i_x,
    input  logic [Y_ADR_SIZE-1:0] i_y,
    output logic [X_ADR_SIZE-1:0] o_x,
    output logic [Y_ADR_SIZE-1:0] o_y
);

    localparam logic [X_ADR_SIZE-1:0] X_MAX = X_ADR_SIZE'(FIELD_W - 1);
    localparam logic [Y_ADR_SIZE-1:0] Y_MAX = Y_ADR_SIZE'(FIELD_H - 1);

    always_comb begin
        o_x = i_x + X_ADR_SIZE'(1);
        o_y = i_y;
        if (i_x == X_MAX) begin
            o_x = '0;
            if (i_y == Y_MAX) begin
                o_y = '0;
            end else begin
                o_y = i_y + Y_ADR_SIZE'(1);
            end
        end
    end

endmodule

module gen_scan_ctrl #(
    parameter  int FIELD_W    = 32,
    parameter  int FIELD_H    = 15,
    localparam int X_ADR_SIZE = $clog2(FIELD_W),
    localparam int Y_ADR_SIZE = $clog2(FIELD_H)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic                  i_ready,
    output logic [X_ADR_SIZE-1:0] o_x,
    output logic [Y_ADR_SIZE-1:0] o_y,
    output logic                  o_valid,
    output logic                  o_last,
    output logic                  o_busy,
    output logic                  o_done
`ifdef GEN_SCAN_GEN_CNT_EN
    ,
    output logic [15:0]           o_gen_cnt
`endif
);

    localparam logic [X_ADR_SIZE-1:0] X_MAX = X_ADR_SIZE'(FIELD_W - 1);
    localparam logic [Y_ADR_SIZE-1:0] Y_MAX = Y_ADR_SIZE'(FIELD_H - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DONE
    } state_e;

    state_e                  state_q;
    logic [X_ADR_SIZE-1:0]   x_q;
    logic [Y_ADR_SIZE-1:0]   y_q;
    logic [X_ADR_SIZE-1:0]   x_d;
    logic [Y_ADR_SIZE-1:0]   y_d;
    logic                    valid_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    handshake;
    logic                    last;

    get_next_coords #(
        .FIELD_W (FIELD_W),
        .FIELD_H (FIELD_H)
    ) u_next (
        .i_x (x_q),
        .i_y (y_q),
        .o_x (x_d),
        .o_y (y_d)
    );

    assign handshake = valid_q & i_ready;
    assign last      = valid_q & (x_q == X_MAX) & (y_q == Y_MAX);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        state_q <= ST_SCAN;
                        x_q     <= '0;
                        y_q     <= '0;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    // Without a handshake nothing moves, so valid and coordinates stay stable.
                    if (handshake) begin
                        if (last) begin
                            state_q <= ST_DONE;
                            x_q     <= '0;
                            y_q     <= '0;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            x_q <= x_d;
                            y_q <= y_d;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    x_q     <= '0;
                    y_q     <= '0;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef GEN_SCAN_GEN_CNT_EN
    logic [15:0] gen_cnt_q;

    // Counts during the DONE cycle, so the new value appears the cycle after o_done.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            gen_cnt_q <= '0;
        end else if (state_q == ST_DONE) begin
            gen_cnt_q <= gen_cnt_q + 16'd1;
        end
    end

    assign o_gen_cnt = gen_cnt_q;
`endif

    assign o_x     = x_q;
    assign o_y     = y_q;
    assign o_valid = valid_q;
    assign o_last  = last;
    assign o_busy  = busy_q;
    assign o_done  = done_q;

endmodule

// File: tb/tb_gen_scan_ctrl.sv
// tb/tb_gen_scan_ctrl.sv - self-checking bench for gen_scan_ctrl (vector table, random ready, reference model)
// Compile with GEN_SCAN_GEN_CNT_EN to also check o_gen_cnt.

module tb_gen_scan_ctrl;

    localparam int W  = 32;
    localparam int H  = 15;
    localparam int N  = W * H;
    localparam int XS = $clog2(W);
    localparam int YS = $clog2(H);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          ready = 1'b0;
    logic [XS-1:0] o_x;
    logic [YS-1:0] o_y;
    logic          o_valid;
    logic          o_last;
    logic          o_busy;
    logic          o_done;
`ifdef GEN_SCAN_GEN_CNT_EN
    logic [15:0]   o_gen_cnt;
`endif

    gen_scan_ctrl #(
        .FIELD_W (W),
        .FIELD_H (H)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_start   (start),
        .i_ready   (ready),
        .o_x       (o_x),
        .o_y       (o_y),
        .o_valid   (o_valid),
        .o_last    (o_last),
        .o_busy    (o_busy),
        .o_done    (o_done)
`ifdef GEN_SCAN_GEN_CNT_EN
        ,
        .o_gen_cnt (o_gen_cnt)
`endif
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;

    // Reference model: phase 0 idle, 1 scanning cell index m_k, 2 done pulse.
    int          m_phase = 0;
    int          m_k = 0;
    logic [15:0] m_gen = 16'd0;

    int          hs_cnt = 0;
    int          dup_cnt = 0;
    int          done_seen = 0;
    bit          seen [N];

    typedef struct {
        logic start;
        logic ready;
        logic exp_valid;
        logic exp_busy;
        logic exp_done;
        int   exp_x;
        int   exp_y;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 20)
                $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_coverage();
        hs_cnt  = 0;
        dup_cnt = 0;
        foreach (seen[i]) seen[i] = 1'b0;
    endtask

    task automatic model_update(input logic s, input logic r);
        case (m_phase)
            0: if (s) begin m_phase = 1; m_k = 0; end
            1: if (r) begin
                   if (m_k == N - 1) m_phase = 2;
                   else m_k++;
               end
            default: begin m_phase = 0; m_gen = m_gen + 16'd1; end
        endcase
    endtask

    task automatic check_model();
        logic ev;
        int   ex, ey;
        ev = (m_phase == 1);
        ex = ev ? (m_k % W) : 0;
        ey = ev ? (m_k / W) : 0;
        chk("valid", 32'(o_valid), 32'(ev));
        chk("x", 32'(o_x), ex);
        chk("y", 32'(o_y), ey);
        chk("last", 32'(o_last), 32'(ev && m_k == N - 1));
        chk("busy", 32'(o_busy), 32'(m_phase != 0));
        chk("done", 32'(o_done), 32'(m_phase == 2));
`ifdef GEN_SCAN_GEN_CNT_EN
        chk("gen_cnt", 32'(o_gen_cnt), 32'(m_gen));
`endif
        if (o_done) begin
            chk("handshakes_per_scan", hs_cnt, N);
            chk("duplicate_coords", dup_cnt, 0);
            clear_coverage();
            done_seen++;
        end
    endtask

    // Drive at the falling edge, let one rising edge pass, check at the next falling edge.
    task automatic step(input logic s, input logic r);
        int idx;
        start = s;
        ready = r;
        if (o_valid && r) begin
            hs_cnt++;
            idx = int'(o_y) * W + int'(o_x);
            if (idx < N) begin
                if (seen[idx]) dup_cnt++;
                seen[idx] = 1'b1;
            end
        end
        model_update(s, r);
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    task automatic run_scan(input bit rnd, input int pulse_k, output int cyc);
        logic r, s;
        int   d0;
        d0  = done_seen;
        r   = rnd ? 1'($urandom % 2) : 1'b1;
        step(1'b1, r);
        cyc = 1;
        while (done_seen == d0 && cyc < 5000) begin
            r = rnd ? 1'($urandom % 2) : 1'b1;
            s = (m_phase == 1 && m_k == pulse_k);
            step(s, r);
            cyc++;
        end
        chk("scan_completed", done_seen - d0, 1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(o_valid), 0);
        chk({tag, "_x"}, 32'(o_x), 0);
        chk({tag, "_y"}, 32'(o_y), 0);
        chk({tag, "_last"}, 32'(o_last), 0);
        chk({tag, "_busy"}, 32'(o_busy), 0);
        chk({tag, "_done"}, 32'(o_done), 0);
`ifdef GEN_SCAN_GEN_CNT_EN
        chk({tag, "_gen_cnt"}, 32'(o_gen_cnt), 32'(m_gen));
`endif
    endtask

    initial begin
        int cyc;
        int d0;
        int guard;

        tbl[0] = '{start: 1'b0, ready: 1'b0, exp_valid: 1'b0, exp_busy: 1'b0, exp_done: 1'b0, exp_x: 0, exp_y: 0};
        tbl[1] = '{start: 1'b0, ready: 1'b1, exp_valid: 1'b0, exp_busy: 1'b0, exp_done: 1'b0, exp_x: 0, exp_y: 0};
        tbl[2] = '{start: 1'b1, ready: 1'b0, exp_valid: 1'b1, exp_busy: 1'b1, exp_done: 1'b0, exp_x: 0, exp_y: 0};
        tbl[3] = '{start: 1'b0, ready: 1'b0, exp_valid: 1'b1, exp_busy: 1'b1, exp_done: 1'b0, exp_x: 0, exp_y: 0};
        tbl[4] = '{start: 1'b0, ready: 1'b1, exp_valid: 1'b1, exp_busy: 1'b1, exp_done: 1'b0, exp_x: 1, exp_y: 0};
        tbl[5] = '{start: 1'b1, ready: 1'b1, exp_valid: 1'b1, exp_busy: 1'b1, exp_done: 1'b0, exp_x: 2, exp_y: 0};
        tbl[6] = '{start: 1'b0, ready: 1'b0, exp_valid: 1'b1, exp_busy: 1'b1, exp_done: 1'b0, exp_x: 2, exp_y: 0};
        tbl[7] = '{start: 1'b0, ready: 1'b1, exp_valid: 1'b1, exp_busy: 1'b1, exp_done: 1'b0, exp_x: 3, exp_y: 0};

        clear_coverage();
        repeat (2) @(negedge clk);
        check_all_zero("in_reset");
        rst_n = 1'b1;

        repeat (10) step(1'b0, 1'($urandom % 2));

        for (int i = 0; i < 8; i++) begin
            step(tbl[i].start, tbl[i].ready);
            chk($sformatf("tbl%0d_valid", i), 32'(o_valid), 32'(tbl[i].exp_valid));
            chk($sformatf("tbl%0d_busy", i), 32'(o_busy), 32'(tbl[i].exp_busy));
            chk($sformatf("tbl%0d_done", i), 32'(o_done), 32'(tbl[i].exp_done));
            chk($sformatf("tbl%0d_x", i), 32'(o_x), tbl[i].exp_x);
            chk($sformatf("tbl%0d_y", i), 32'(o_y), tbl[i].exp_y);
        end

        // Continue the table's scan to (5,7), then abort it with an asynchronous reset.
        guard = 0;
        while (m_k != 7 * W + 5 && guard < 1000) begin
            step(1'b0, 1'b1);
            guard++;
        end
        chk("reached_5_7", 32'(m_k), 7 * W + 5);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        m_phase = 0;
        m_k     = 0;
        clear_coverage();
        @(negedge clk);
        check_all_zero("reset_held");
        start = 1'b0;
        rst_n = 1'b1;
        repeat (3) step(1'b0, 1'b1);

        run_scan(1'b0, -1, cyc);
        chk("latency_to_done", cyc, N + 1);
        repeat (2) step(1'b0, 1'b1);

        run_scan(1'b1, -1, cyc);
        repeat (2) step(1'b0, 1'($urandom % 2));

        d0 = done_seen;
        run_scan(1'b1, 2 * W + 10, cyc);
        repeat (3) step(1'b0, 1'b1);
        chk("single_done_with_pulse", done_seen - d0, 1);

        d0  = done_seen;
        cyc = 0;
        while (done_seen - d0 < 3 && cyc < 3 * (N + 2) + 10) begin
            step(1'b1, 1'b1);
            cyc++;
        end
        chk("b2b_dones", done_seen - d0, 3);
        chk("b2b_cycles", cyc, 3 * (N + 2) - 1);
        repeat (3) step(1'b0, 1'b1);

        repeat (40) step(1'($urandom % 2), 1'($urandom % 2));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
